// File: rtl/opcode_fetch_if.sv
// Memory read bus plus decoder bundle for the opcode fetch front end.
//   master : opcode_fetch side (drives address/request and the bundle,
//            receives read data and the consumer's op_ack)
//   slave  : memory / instruction decoder side
// Signals:
//   mem_addr, mem_rd_req          byte read request (registered)
//   mem_rdy, mem_data_i           read data return, valid when mem_rdy=1
//   opcode, postbyte0, eapostbyte instruction bytes
//   page2_valid, page3_valid      page qualifiers for postbyte0
//   op_valid, illegal_o           bundle valid / prefix-chain overflow
//   op_ack                        consumer has taken the bundle
interface opcode_fetch_if;
  logic [15:0] mem_addr;
  logic        mem_rd_req;
  logic        mem_rdy;
  logic [7:0]  mem_data_i;
  logic [7:0]  opcode;
  logic [7:0]  postbyte0;
  logic [7:0]  eapostbyte;
  logic        page2_valid;
  logic        page3_valid;
  logic        op_valid;
  logic        illegal_o;
  logic        op_ack;

  modport master (
    output mem_addr, mem_rd_req,
    input  mem_rdy, mem_data_i,
    output opcode, postbyte0, eapostbyte, page2_valid, page3_valid,
    output op_valid, illegal_o,
    input  op_ack
  );

  modport slave (
    input  mem_addr, mem_rd_req,
    output mem_rdy, mem_data_i,
    input  opcode, postbyte0, eapostbyte, page2_valid, page3_valid,
    input  op_valid, illegal_o,
    output op_ack
  );
endinterface

// File: rtl/opcode_fetch.sv
// Front-end byte sequencer for the 6809/6309-compatible core.
// Fetches the opcode at PC, resolves 0x10/0x11 page prefixes, gathers the
// register-list/TFR operand byte and the indexed EA postbyte, and holds the
// result as a registered bundle until the sequencer acknowledges it.
// Ports:
//   cpu_clk, cpu_reset_n  clock, asynchronous active-low reset
//   pc_load, pc_i         load new PC (also aborts any fetch)
//   fetch_req             request the next instruction
//   flush                 abort the fetch and drop the bundle
//   bus                   memory bus + decoder bundle (master modport)
//   pc_o                  address of the byte after the last consumed byte
module opcode_fetch #(
  parameter int unsigned MAX_PREFIX = 3,
  parameter logic [15:0] RESET_PC   = 16'hFFFE
) (
  input  logic            cpu_clk,
  input  logic            cpu_reset_n,
  input  logic            pc_load,
  input  logic [15:0]     pc_i,
  input  logic            fetch_req,
  input  logic            flush,
  opcode_fetch_if.master  bus,
  output logic [15:0]     pc_o
);

  typedef enum logic [2:0] {
    IDLE,
    F_OP,
    F_PB,
    F_EA,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  pb0_q, pb0_d;
  logic [7:0]  ea_q, ea_d;
  logic        p2_q, p2_d;
  logic        p3_q, p3_d;
  logic        ill_q, ill_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        page_q, page_d;     // 1: last prefix was 0x11
  logic        pfx_q, pfx_d;       // current instruction is page-prefixed
  logic        rd_q, rd_d;
  logic        vld_q, vld_d;

  logic        accept;
  logic [7:0]  b;

  assign accept = rd_q & bus.mem_rdy;
  assign b      = bus.mem_data_i;

  function automatic logic is_prefix(input logic [7:0] x);
    return (x == 8'h10) || (x == 8'h11);
  endfunction

  // Page-1 opcodes followed by a register-list / TFR / EXG operand byte
  function automatic logic is_reglist(input logic [7:0] x);
    return (x == 8'h1E) || (x == 8'h1F) || (x[7:2] == 6'b001101);
  endfunction

  // Page-1 indexed opcodes: LEAx (0x30-0x33) and the 0x6x/0xAx/0xEx groups
  function automatic logic is_indexed(input logic [7:0] x);
    return (x[7:2] == 6'b001100) || (x[7:4] == 4'h6) ||
           (x[7:4] == 4'hA) || (x[7:4] == 4'hE);
  endfunction

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    pb0_d    = pb0_q;
    ea_d     = ea_q;
    p2_d     = p2_q;
    p3_d     = p3_q;
    ill_d    = ill_q;
    cnt_d    = cnt_q;
    page_d   = page_q;
    pfx_d    = pfx_q;

    if (pc_load || flush) begin
      // An abort takes priority over any byte arriving this cycle, so PC
      // only reflects bytes accepted on earlier cycles.
      state_d = IDLE;
      p2_d    = 1'b0;
      p3_d    = 1'b0;
      ill_d   = 1'b0;
      if (pc_load) pc_d = pc_i;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fetch_req) begin
            p2_d    = 1'b0;
            p3_d    = 1'b0;
            ill_d   = 1'b0;
            cnt_d   = '0;
            state_d = F_OP;
          end
        end

        F_OP: begin
          if (accept) begin
            pc_d     = pc_q + 16'd1;
            opcode_d = b;
            if (is_prefix(b)) begin
              cnt_d   = cnt_q + 8'd1;
              page_d  = b[0];
              pfx_d   = 1'b1;
              state_d = F_PB;
            end else begin
              pfx_d = 1'b0;
              if (is_reglist(b))      state_d = F_PB;
              else if (is_indexed(b)) state_d = F_EA;
              else                    state_d = HOLD;
            end
          end
        end

        F_PB: begin
          if (accept) begin
            pc_d = pc_q + 16'd1;
            if (!pfx_q) begin
              pb0_d   = b;
              state_d = HOLD;
            end else if (is_prefix(b)) begin
              if (cnt_q < 8'(MAX_PREFIX)) begin
                opcode_d = b;
                page_d   = b[0];
                cnt_d    = cnt_q + 8'd1;
              end else begin
                ill_d   = 1'b1;
                pb0_d   = b;
                state_d = HOLD;
              end
            end else begin
              pb0_d   = b;
              p2_d    = ~page_q;
              p3_d    = page_q;
              state_d = ((b[7:4] == 4'hA) || (b[7:4] == 4'hE)) ? F_EA : HOLD;
            end
          end
        end

        F_EA: begin
          if (accept) begin
            pc_d    = pc_q + 16'd1;
            ea_d    = b;
            state_d = HOLD;
          end
        end

        HOLD: begin
          if (bus.op_ack) begin
            if (fetch_req) begin
              p2_d    = 1'b0;
              p3_d    = 1'b0;
              ill_d   = 1'b0;
              cnt_d   = '0;
              state_d = F_OP;
            end else begin
              state_d = IDLE;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end

    // Request and valid are registered images of the next state
    rd_d  = (state_d == F_OP) || (state_d == F_PB) || (state_d == F_EA);
    vld_d = (state_d == HOLD);
  end

  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      opcode_q <= '0;
      pb0_q    <= '0;
      ea_q     <= '0;
      p2_q     <= 1'b0;
      p3_q     <= 1'b0;
      ill_q    <= 1'b0;
      cnt_q    <= '0;
      page_q   <= 1'b0;
      pfx_q    <= 1'b0;
      rd_q     <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      pb0_q    <= pb0_d;
      ea_q     <= ea_d;
      p2_q     <= p2_d;
      p3_q     <= p3_d;
      ill_q    <= ill_d;
      cnt_q    <= cnt_d;
      page_q   <= page_d;
      pfx_q    <= pfx_d;
      rd_q     <= rd_d;
      vld_q    <= vld_d;
    end
  end

  // mem_addr and pc_o are the same PC register
  assign bus.mem_addr    = pc_q;
  assign bus.mem_rd_req  = rd_q;
  assign bus.opcode      = opcode_q;
  assign bus.postbyte0   = pb0_q;
  assign bus.eapostbyte  = ea_q;
  assign bus.page2_valid = p2_q;
  assign bus.page3_valid = p3_q;
  assign bus.op_valid    = vld_q;
  assign bus.illegal_o   = ill_q;
  assign pc_o            = pc_q;

endmodule

// File: tb/tb_opcode_fetch.sv
// Directed testbench for opcode_fetch: byte memory model with configurable
// ready stalls, hand-computed expected bundles for each instruction form.
module tb_opcode_fetch;

  logic        clk = 1'b0;
  logic        cpu_reset_n;
  logic        pc_load;
  logic [15:0] pc_i;
  logic        fetch_req;
  logic        flush;
  logic [15:0] pc_o;

  opcode_fetch_if bus();

  opcode_fetch #(.MAX_PREFIX(3), .RESET_PC(16'hFFFE)) dut (
    .cpu_clk    (clk),
    .cpu_reset_n(cpu_reset_n),
    .pc_load    (pc_load),
    .pc_i       (pc_i),
    .fetch_req  (fetch_req),
    .flush      (flush),
    .bus        (bus),
    .pc_o       (pc_o)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, mem_rdy after stall_cfg wait cycles
  logic [7:0]  mem [65536];
  int unsigned stall_cfg = 0;
  int unsigned wcnt = 0;
  logic        rdy_block = 1'b0;

  assign bus.mem_data_i = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_rd_req && bus.mem_rdy) wcnt = 0;
    else if (bus.mem_rd_req)           wcnt = wcnt + 1;
    else                               wcnt = 0;
  end

  always @(negedge clk) begin
    bus.mem_rdy = bus.mem_rd_req && !rdy_block && (wcnt >= stall_cfg);
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // pc_load for one cycle, then fetch_req for one cycle; returns with the
  // DUT in F_OP
  task automatic start_fetch(input logic [15:0] a);
    pc_load = 1'b1; pc_i = a;
    cyc();
    pc_load = 1'b0; fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int unsigned n = 0;
    while (!bus.op_valid && n < 100) begin
      cyc();
      n++;
    end
    check(tag, 32'(bus.op_valid), 1);
  endtask

  task automatic ack();
    bus.op_ack = 1'b1;
    cyc();
    bus.op_ack = 1'b0;
    check("ack_drop", 32'(bus.op_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h12;
    mem[16'hFFFE] = 8'h86;
    mem[16'h1000] = 8'h10; mem[16'h1001] = 8'hAE; mem[16'h1002] = 8'h84;
    mem[16'h2000] = 8'h11; mem[16'h2001] = 8'h11; mem[16'h2002] = 8'h10; mem[16'h2003] = 8'h8C;
    mem[16'h3000] = 8'h10; mem[16'h3001] = 8'h10; mem[16'h3002] = 8'h10; mem[16'h3003] = 8'h10;
    mem[16'h4000] = 8'h1F; mem[16'h4001] = 8'h89;
    mem[16'h5000] = 8'h6A; mem[16'h5001] = 8'h12; mem[16'h5002] = 8'h3A;

    cpu_reset_n = 1'b0; pc_load = 1'b0; pc_i = '0;
    fetch_req = 1'b0; flush = 1'b0; bus.op_ack = 1'b0;
    repeat (3) cyc();

    check("rst_valid", 32'(bus.op_valid), 0);
    check("rst_rdreq", 32'(bus.mem_rd_req), 0);
    check("rst_addr",  32'(bus.mem_addr), 'hFFFE);
    check("rst_pc",    32'(pc_o), 'hFFFE);
    check("rst_op",    32'(bus.opcode), 0);
    check("rst_pb0",   32'(bus.postbyte0), 0);
    check("rst_ea",    32'(bus.eapostbyte), 0);
    check("rst_flags", 32'({bus.page2_valid, bus.page3_valid, bus.illegal_o}), 0);
    cpu_reset_n = 1'b1;
    cyc();

    // Simple page-1 opcode straight from reset PC
    fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
    check("t1_nv",    32'(bus.op_valid), 0);
    check("t1_rdreq", 32'(bus.mem_rd_req), 1);
    check("t1_addr",  32'(bus.mem_addr), 'hFFFE);
    cyc();
    check("t1_valid", 32'(bus.op_valid), 1);
    check("t1_op",    32'(bus.opcode), 'h86);
    check("t1_flags", 32'({bus.page2_valid, bus.page3_valid}), 0);
    check("t1_pc",    32'(pc_o), 'hFFFF);
    check("t1_rdreq_hold", 32'(bus.mem_rd_req), 0);
    ack();

    // Page-2 indexed: 10 AE 84
    start_fetch(16'h1000);
    wait_valid("t2_valid");
    check("t2_op",  32'(bus.opcode), 'h10);
    check("t2_pb0", 32'(bus.postbyte0), 'hAE);
    check("t2_p2",  32'(bus.page2_valid), 1);
    check("t2_p3",  32'(bus.page3_valid), 0);
    check("t2_ea",  32'(bus.eapostbyte), 'h84);
    check("t2_pc",  32'(pc_o), 'h1003);
    check("t2_ill", 32'(bus.illegal_o), 0);
    ack();

    // Prefix chain within limit, last prefix wins: 11 11 10 8C
    start_fetch(16'h2000);
    wait_valid("t3_valid");
    check("t3_op",  32'(bus.opcode), 'h10);
    check("t3_pb0", 32'(bus.postbyte0), 'h8C);
    check("t3_p2",  32'(bus.page2_valid), 1);
    check("t3_p3",  32'(bus.page3_valid), 0);
    check("t3_ill", 32'(bus.illegal_o), 0);
    check("t3_pc",  32'(pc_o), 'h2004);
    ack();

    // Prefix chain overflow: 10 10 10 10
    start_fetch(16'h3000);
    wait_valid("t4_valid");
    check("t4_ill",   32'(bus.illegal_o), 1);
    check("t4_flags", 32'({bus.page2_valid, bus.page3_valid}), 0);
    check("t4_pb0",   32'(bus.postbyte0), 'h10);
    check("t4_pc",    32'(pc_o), 'h3004);
    ack();

    // TFR with 3 wait cycles per byte: 1F 89
    stall_cfg = 3;
    start_fetch(16'h4000);
    for (int k = 1; k <= 8; k++) begin
      check("t5_addr", 32'(bus.mem_addr), (k <= 4) ? 'h4000 : 'h4001);
      check("t5_nv",   32'(bus.op_valid), 0);
      cyc();
    end
    check("t5_valid", 32'(bus.op_valid), 1);
    check("t5_op",    32'(bus.opcode), 'h1F);
    check("t5_pb0",   32'(bus.postbyte0), 'h89);
    check("t5_flags", 32'({bus.page2_valid, bus.page3_valid}), 0);
    check("t5_pc",    32'(pc_o), 'h4002);
    ack();
    stall_cfg = 0;

    // Flush while waiting for the EA postbyte after 6A
    start_fetch(16'h5000);
    @(posedge clk);
    #1 rdy_block = 1'b1;
    cyc();
    check("t6_rdreq_ea", 32'(bus.mem_rd_req), 1);
    check("t6_pc_ea",    32'(pc_o), 'h5001);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("t6_nv",    32'(bus.op_valid), 0);
    check("t6_rdreq", 32'(bus.mem_rd_req), 0);
    check("t6_pc",    32'(pc_o), 'h5001);
    cyc();
    check("t6_nv2", 32'(bus.op_valid), 0);
    rdy_block = 1'b0;
    fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
    check("t6_re_rdreq", 32'(bus.mem_rd_req), 1);
    check("t6_re_addr",  32'(bus.mem_addr), 'h5001);
    cyc();
    check("t6_re_valid", 32'(bus.op_valid), 1);
    check("t6_re_op",    32'(bus.opcode), 'h12);
    check("t6_re_pc",    32'(pc_o), 'h5002);

    // Back-to-back: op_ack with fetch_req in HOLD skips IDLE
    bus.op_ack = 1'b1; fetch_req = 1'b1;
    cyc();
    bus.op_ack = 1'b0; fetch_req = 1'b0;
    check("t7_nv",    32'(bus.op_valid), 0);
    check("t7_rdreq", 32'(bus.mem_rd_req), 1);
    cyc();
    check("t7_valid", 32'(bus.op_valid), 1);
    check("t7_op",    32'(bus.opcode), 'h3A);
    check("t7_pc",    32'(pc_o), 'h5003);

    // Asynchronous reset while holding a bundle
    #2 cpu_reset_n = 1'b0;
    #1;
    check("t8_valid", 32'(bus.op_valid), 0);
    check("t8_addr",  32'(bus.mem_addr), 'hFFFE);
    check("t8_op",    32'(bus.opcode), 0);
    cyc();
    cpu_reset_n = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/opcode_fetch.md
Name: opcode_fetch

Overview:
- Front-end byte sequencer for the 6809/6309-compatible core.
- Reads instruction bytes from memory at PC and resolves the 0x10/0x11 page prefixes.
- Gathers the register-list/TFR byte and the indexed EA postbyte.
- Presents opcode, postbyte0, page2_valid, page3_valid and eapostbyte as a stable, registered bundle: the producer side of the instruction decoders' input interface.

Parameters:
- MAX_PREFIX, 3, maximum consecutive prefix bytes consumed before the instruction is flagged illegal.
- RESET_PC, 16'hFFFE, PC value after reset.

Ports:
- cpu_clk  in  1  core clock, all state on rising edge
- cpu_reset_n  in  1  asynchronous active-low reset
- pc_load  in  1  load pc_i into PC; wins over all fetch activity
- pc_i  in  16  new PC value
- fetch_req  in  1  sequencer requests the next instruction
- flush  in  1  abort the current fetch and drop the output bundle
- op_ack  in  1  sequencer has consumed the bundle
- mem_addr  out  16  byte address
- mem_rd_req  out  1  memory read request
- mem_rdy  in  1  mem_data_i valid this cycle
- mem_data_i  in  8  read byte
- opcode  out  8  page-1 opcode (0x10 or 0x11 when prefixed)
- postbyte0  out  8  page-2/3 opcode, or TFR/EXG/PSH/PUL operand byte
- page2_valid  out  1  postbyte0 is a page-2 opcode
- page3_valid  out  1  postbyte0 is a page-3 opcode
- eapostbyte  out  8  indexed-mode postbyte
- op_valid  out  1  bundle valid
- illegal_o  out  1  prefix chain exceeded MAX_PREFIX
- pc_o  out  16  PC of the byte after the last consumed byte

Behaviour:
- Reset:
  - State IDLE; PC=RESET_PC.
  - All byte outputs 8'h00.
  - page2_valid, page3_valid, op_valid, illegal_o, mem_rd_req all 0.
  - mem_addr=RESET_PC.
- States: IDLE, F_OP, F_PB, F_EA, HOLD.
- Memory handshake:
  - mem_rd_req=1 and mem_addr=PC, both registered, for the whole time in F_OP/F_PB/F_EA.
  - Byte accepted on a cycle with mem_rdy=1; PC increments (mod 2^16) in the same cycle.
  - mem_rdy is ignored while mem_rd_req=0.
- IDLE:
  - If fetch_req: clear page flags, illegal_o and the prefix count, then go to F_OP.
- F_OP, on accept:
  - Byte 0x10 or 0x11: opcode=byte, increment prefix count, remember the page, go to F_PB.
  - Page-1 byte in {0x1E, 0x1F, 0x34-0x37}: go to F_PB.
  - Page-1 indexed byte (0x30-0x33, 0x6x, 0xAx, 0xEx): go to F_EA.
  - Any other byte: go to HOLD.
- F_PB, prefixed instruction, on accept:
  - Byte is 0x10/0x11 and prefix count < MAX_PREFIX: consume it, last prefix wins (updates opcode and page), stay in F_PB.
  - Byte is 0x10/0x11 and prefix count = MAX_PREFIX: illegal_o=1, postbyte0=byte, no page flag, go to HOLD.
  - Otherwise: postbyte0=byte; page2_valid = (page==0x10), page3_valid = (page==0x11).
  - Then go to F_EA if byte[7:4] is 0xA or 0xE, else HOLD.
- F_PB, page-1 operand byte, on accept: postbyte0=byte, go to HOLD.
- F_EA, on accept: eapostbyte=byte, go to HOLD.
- HOLD:
  - op_valid=1; all outputs stable.
  - op_ack: op_valid drops the next cycle.
  - op_ack with fetch_req in the same cycle: clear flags and go straight to F_OP (back-to-back fetch, no IDLE bubble).
  - op_ack alone: go to IDLE.
- flush (any state):
  - Next state IDLE; op_valid, page2_valid, page3_valid, illegal_o and mem_rd_req cleared.
  - PC keeps the bytes already consumed.
- pc_load (any state): PC=pc_i, mem_addr=pc_i, plus all flush effects. If pc_load and flush arrive together, pc_load wins.
- Reset mid-operation: immediate return to reset values.
- Offset and extended operand bytes are not fetched here; they belong to the execution sequencer, which starts from pc_o.

Test Plan:
- Reset, then fetch_req with memory at 0xFFFE = 0x86 (mem_rdy every cycle) -> opcode=0x86, page flags 0, op_valid in the 2nd cycle after fetch_req, pc_o=0xFFFF.
- pc_load 0x1000, bytes 10 AE 84 -> opcode=0x10, postbyte0=0xAE, page2_valid=1, eapostbyte=0x84, pc_o=0x1003.
- Bytes 11 11 10 8C with MAX_PREFIX=3 -> opcode=0x10, postbyte0=0x8C, page2_valid=1, page3_valid=0, illegal_o=0.
- Bytes 10 10 10 10 -> illegal_o=1, page flags 0, pc_o=start+4.
- Bytes 1F 89 with mem_rdy stalled 3 cycles per byte -> mem_addr steady during each stall, postbyte0=0x89, op_valid only after the 2nd byte.
- flush asserted in F_EA after 6x -> no op_valid; pc_o=start+1; next fetch_req restarts cleanly in F_OP. Also op_ack together with fetch_req in HOLD -> no IDLE cycle.
